// File: rtl/fetch_ifid_stage.sv
// IF stage and IF/ID pipeline register for the pipelined MIPS core.
// Holds the fetch PC, latches the fetched word into ID, slices the ID word
// for the decoder AND-plane, and resolves beq/j/jal/jr next-PC in ID with one
// architectural delay slot (the word fetched alongside a redirect is kept).
module fetch_ifid_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] im_data,
    input  logic        dec_beq,
    input  logic        dec_j,
    input  logic        dec_jal,
    input  logic        dec_jr,
    input  logic [31:0] rs_fwd,
    input  logic [31:0] rt_fwd,
    output logic [31:0] im_addr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        op_d,
    output logic [5:0]  f_d,
    output logic        redirect
);

    // Fetch PC (IF) and IF/ID register contents
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] ir_q,  ir_d;
    logic [31:0] pcid_q, pcid_d;

    logic [31:0]        pc4_id;
    logic signed [31:0] imm_sx;
    logic [31:0]        br_tgt;
    logic [31:0]        jt;
    logic               eq;
    logic               br_taken;
    logic [31:0]        npc;

    // Word-aligned branch offset: sign-extend the 16-bit immediate, scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        logic signed [31:0] sx;
        sx = {{16{imm[15]}}, imm};
        return 32'(sx <<< 2);
    endfunction

    assign pc4_id   = pcid_q + 32'd4;
    assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign br_tgt   = pc4_id + branch_offset(imm_sx[15:0]);
    assign jt       = {pc4_id[31:28], ir_q[25:0], 2'b00};
    assign eq       = (rs_fwd == rt_fwd);
    assign br_taken = dec_beq & eq;

    // Next-PC select; jr outranks j/jal, which outrank a taken beq
    always_comb begin
        npc = pcf_q + 32'd4;
        if (dec_jr) begin
            npc = rs_fwd;
        end else if (dec_j | dec_jal) begin
            npc = jt;
        end else if (br_taken) begin
            npc = br_tgt;
        end
    end

    // Register next-state: advance unless stalled, which freezes IF and ID together
    always_comb begin
        pcf_d  = pcf_q;
        ir_d   = ir_q;
        pcid_d = pcid_q;
        if (!stall) begin
            pcf_d  = npc;
            ir_d   = im_data;
            pcid_d = pcf_q;
        end
    end

    // State update; reset takes precedence over stall
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q  <= PC_RESET;
            ir_q   <= NOP_WORD;
            pcid_q <= 32'd0;
        end else begin
            pcf_q  <= pcf_d;
            ir_q   <= ir_d;
            pcid_q <= pcid_d;
        end
    end

    assign im_addr  = pcf_q;
    assign instr_d  = ir_q;
    assign pc_d     = pcid_q;
    assign pc8_d    = pcid_q + 32'd8;
    assign op_d     = |ir_q[31:26];
    assign f_d      = op_d ? ir_q[31:26] : ir_q[5:0];
    assign redirect = dec_jr | dec_j | dec_jal | br_taken;

endmodule
